// File: rtl/leak_det_filter_if.sv
// Leak detector filter signal bundle: sensor/tick/latch inputs and filtered outputs.
interface leak_det_filter_if;
    logic       iTick_1ms;
    logic       iLarge_Leak_Raw_N;
    logic       iSmall_Leak_Raw_N;
    logic       iLatch_En;
    logic       iLatch_Clear;
    logic       oLarge_Leak_Detect_N;
    logic       oSmall_Leak_Detect_N;
    logic       oLeak_Event;
    logic [7:0] oLarge_Evt_Cnt;
    logic [7:0] oSmall_Evt_Cnt;
    logic [1:0] oDBG_Large_FSM;
    logic [1:0] oDBG_Small_FSM;

    // Stimulus side: drives sensors, tick and latch controls
    modport master (
        output iTick_1ms, iLarge_Leak_Raw_N, iSmall_Leak_Raw_N, iLatch_En, iLatch_Clear,
        input  oLarge_Leak_Detect_N, oSmall_Leak_Detect_N, oLeak_Event,
               oLarge_Evt_Cnt, oSmall_Evt_Cnt, oDBG_Large_FSM, oDBG_Small_FSM
    );

    // Filter side
    modport slave (
        input  iTick_1ms, iLarge_Leak_Raw_N, iSmall_Leak_Raw_N, iLatch_En, iLatch_Clear,
        output oLarge_Leak_Detect_N, oSmall_Leak_Detect_N, oLeak_Event,
               oLarge_Evt_Cnt, oSmall_Evt_Cnt, oDBG_Large_FSM, oDBG_Small_FSM
    );
endinterface

// File: rtl/leak_det_filter.sv
// Leak detector debounce filter: two identical channels (index 0 = large, 1 = small),
// each with a 2-flop synchronizer, a 16-bit ms-tick counter and a debounce FSM.
module leak_det_filter #(
    parameter int unsigned DEB_ASSERT_MS   = 20,
    parameter int unsigned DEB_DEASSERT_MS = 100
) (
    input logic               iClk,
    input logic               iRst,
    leak_det_filter_if.slave  bus
);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        PEND  = 2'd1,
        LEAK  = 2'd2,
        RECOV = 2'd3
    } state_t;

    localparam logic [16:0] ASSERT_LIM   = 17'(DEB_ASSERT_MS);
    localparam logic [16:0] DEASSERT_LIM = 17'(DEB_DEASSERT_MS);

    logic [1:0]  sync1_q;
    logic [1:0]  s_n;
    state_t      state_q [2];
    state_t      state_d [2];
    logic [15:0] cnt_q   [2];
    logic [15:0] cnt_d   [2];
    logic [7:0]  evt_q   [2];
    logic [1:0]  det_n_q;
    logic        event_q;
    logic [1:0]  declare;

    // Per-channel next-state and counter logic; a level change on s_n wins over a tick
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        declare = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            case (state_q[i])
                CLEAR: begin
                    if (!s_n[i]) begin
                        state_d[i] = PEND;
                        cnt_d[i]   = '0;
                    end
                end
                PEND: begin
                    if (s_n[i]) begin
                        state_d[i] = CLEAR;
                    end else if (bus.iTick_1ms) begin
                        if ({1'b0, cnt_q[i]} + 17'd1 == ASSERT_LIM) begin
                            state_d[i] = LEAK;
                            declare[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 16'd1;
                        end
                    end
                end
                LEAK: begin
                    if (bus.iLatch_En) begin
                        if (bus.iLatch_Clear && s_n[i]) begin
                            state_d[i] = CLEAR;
                        end
                    end else if (s_n[i]) begin
                        state_d[i] = RECOV;
                        cnt_d[i]   = '0;
                    end
                end
                RECOV: begin
                    if (!s_n[i]) begin
                        state_d[i] = LEAK;
                    end else if (bus.iTick_1ms) begin
                        if ({1'b0, cnt_q[i]} + 17'd1 == DEASSERT_LIM) begin
                            state_d[i] = CLEAR;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 16'd1;
                        end
                    end
                end
                default: state_d[i] = CLEAR;
            endcase
        end
    end

    // Synchronizers, state, counters and registered outputs
    always_ff @(posedge iClk) begin
        if (iRst) begin
            sync1_q <= '1;
            s_n     <= '1;
            det_n_q <= '1;
            event_q <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i] <= CLEAR;
                cnt_q[i]   <= '0;
                evt_q[i]   <= '0;
            end
        end else begin
            sync1_q <= {bus.iSmall_Leak_Raw_N, bus.iLarge_Leak_Raw_N};
            s_n     <= sync1_q;
            event_q <= |declare;
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                // output follows the next state so it falls in the same update as PEND->LEAK
                det_n_q[i] <= !(state_d[i] == LEAK || state_d[i] == RECOV);
                if (declare[i] && evt_q[i] != 8'hFF) begin
                    evt_q[i] <= evt_q[i] + 8'd1;
                end
            end
        end
    end

    assign bus.oLarge_Leak_Detect_N = det_n_q[0];
    assign bus.oSmall_Leak_Detect_N = det_n_q[1];
    assign bus.oLeak_Event          = event_q;
    assign bus.oLarge_Evt_Cnt       = evt_q[0];
    assign bus.oSmall_Evt_Cnt       = evt_q[1];
    assign bus.oDBG_Large_FSM       = state_q[0];
    assign bus.oDBG_Small_FSM       = state_q[1];

endmodule

// File: tb/tb_leak_det_filter.sv
// Directed bench for leak_det_filter: vector table plus hand-written corner sequences.
module tb_leak_det_filter;

    logic iClk = 1'b0;
    logic iRst = 1'b1;

    leak_det_filter_if bus ();

    leak_det_filter #(
        .DEB_ASSERT_MS   (20),
        .DEB_DEASSERT_MS (100)
    ) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic       l;
        logic       s;
        logic       le;
        logic       clr;
        int         nt;
        logic       dl;
        logic       ds;
        logic [1:0] fl;
        logic [1:0] fs;
        logic [7:0] cl;
        logic [7:0] cs;
    } vec_t;

    vec_t vecs [20];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   ev_hits = 0;

    // Count oLeak_Event high samples for pulse-width checks
    always @(negedge iClk) begin
        if (bus.oLeak_Event === 1'b1) ev_hits++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        bus.iTick_1ms = 1'b1;
        @(negedge iClk);
        bus.iTick_1ms = 1'b0;
        @(negedge iClk);
    endtask

    task automatic do_reset();
        @(negedge iClk);
        iRst = 1'b1;
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
    endtask

    task automatic set_in(input logic l, input logic s, input logic le, input logic clr);
        bus.iLarge_Leak_Raw_N = l;
        bus.iSmall_Leak_Raw_N = s;
        bus.iLatch_En         = le;
        bus.iLatch_Clear      = clr;
    endtask

    task automatic check_all(input string tag, input logic dl, input logic ds,
                             input logic [1:0] fl, input logic [1:0] fs,
                             input logic [7:0] cl, input logic [7:0] cs);
        chk({tag, ".det_l"}, 32'(bus.oLarge_Leak_Detect_N), 32'(dl));
        chk({tag, ".det_s"}, 32'(bus.oSmall_Leak_Detect_N), 32'(ds));
        chk({tag, ".fsm_l"}, 32'(bus.oDBG_Large_FSM), 32'(fl));
        chk({tag, ".fsm_s"}, 32'(bus.oDBG_Small_FSM), 32'(fs));
        chk({tag, ".cnt_l"}, 32'(bus.oLarge_Evt_Cnt), 32'(cl));
        chk({tag, ".cnt_s"}, 32'(bus.oSmall_Evt_Cnt), 32'(cs));
    endtask

    // One latched declaration on both channels, then raw release plus clear
    task automatic leak_cycle();
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge iClk);
        repeat (20) tick();
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge iClk);
        bus.iLatch_Clear = 1'b0;
    endtask

    initial begin
        bus.iTick_1ms = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 1'b0);

        //                 l  s  le clr nt   dl ds fl fs cl cs
        vecs[0]  = '{1, 1, 0, 0, 0,   1, 1, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 19,  1, 1, 1, 0, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 1,   0, 1, 2, 0, 1, 0};
        vecs[3]  = '{1, 1, 0, 0, 99,  0, 1, 3, 0, 1, 0};
        vecs[4]  = '{0, 1, 0, 0, 0,   0, 1, 2, 0, 1, 0};
        vecs[5]  = '{1, 1, 0, 0, 100, 1, 1, 0, 0, 1, 0};
        vecs[6]  = '{1, 0, 0, 0, 19,  1, 1, 0, 1, 1, 0};
        vecs[7]  = '{1, 1, 0, 0, 0,   1, 1, 0, 0, 1, 0};
        vecs[8]  = '{1, 0, 0, 0, 19,  1, 1, 0, 1, 1, 0};
        vecs[9]  = '{1, 0, 0, 0, 1,   1, 0, 0, 2, 1, 1};
        vecs[10] = '{1, 0, 1, 1, 0,   1, 0, 0, 2, 1, 1};
        vecs[11] = '{1, 1, 1, 0, 5,   1, 0, 0, 2, 1, 1};
        vecs[12] = '{1, 1, 1, 1, 0,   1, 1, 0, 0, 1, 1};
        vecs[13] = '{1, 1, 0, 0, 3,   1, 1, 0, 0, 1, 1};
        vecs[14] = '{0, 0, 0, 0, 20,  0, 0, 2, 2, 2, 2};
        vecs[15] = '{1, 1, 0, 0, 100, 1, 1, 0, 0, 2, 2};
        vecs[16] = '{0, 0, 1, 0, 20,  0, 0, 2, 2, 3, 3};
        vecs[17] = '{1, 1, 1, 0, 3,   0, 0, 2, 2, 3, 3};
        vecs[18] = '{1, 1, 0, 0, 0,   0, 0, 3, 3, 3, 3};
        vecs[19] = '{1, 1, 0, 0, 100, 1, 1, 0, 0, 3, 3};

        // Reset state
        do_reset();
        @(negedge iClk);
        check_all("reset", 1'b1, 1'b1, 2'd0, 2'd0, 8'd0, 8'd0);
        chk("reset.event", 32'(bus.oLeak_Event), 32'd0);

        // Table: drive, let the synchronizer settle, apply ticks, compare
        for (int v = 0; v < 20; v++) begin
            set_in(vecs[v].l, vecs[v].s, vecs[v].le, vecs[v].clr);
            repeat (4) @(negedge iClk);
            for (int t = 0; t < vecs[v].nt; t++) tick();
            check_all($sformatf("vec%0d", v), vecs[v].dl, vecs[v].ds,
                      vecs[v].fl, vecs[v].fs, vecs[v].cl, vecs[v].cs);
        end

        // Exact declaration timing and single-cycle event pulse on the 20th tick
        do_reset();
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge iClk);
        repeat (19) tick();
        chk("lat.pre_det", 32'(bus.oLarge_Leak_Detect_N), 32'd1);
        bus.iTick_1ms = 1'b1;
        @(negedge iClk);
        bus.iTick_1ms = 1'b0;
        chk("lat.det", 32'(bus.oLarge_Leak_Detect_N), 32'd0);
        chk("lat.event", 32'(bus.oLeak_Event), 32'd1);
        chk("lat.cnt", 32'(bus.oLarge_Evt_Cnt), 32'd1);
        @(negedge iClk);
        chk("lat.event_end", 32'(bus.oLeak_Event), 32'd0);

        // Simultaneous declarations: one pulse, both counts
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge iClk);
        ev_hits = 0;
        repeat (20) tick();
        repeat (3) @(negedge iClk);
        chk("both.pulses", 32'(ev_hits), 32'd1);
        check_all("both", 1'b0, 1'b0, 2'd2, 2'd2, 8'd1, 8'd1);

        // Latched: raw high, clear applied -> CLEAR on the next cycle
        set_in(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge iClk);
        chk("latch.hold", 32'(bus.oLarge_Leak_Detect_N), 32'd0);
        bus.iLatch_Clear = 1'b1;
        @(negedge iClk);
        bus.iLatch_Clear = 1'b0;
        check_all("latch.clr", 1'b1, 1'b1, 2'd0, 2'd0, 8'd1, 8'd1);

        // Saturation of both event counts
        for (int n = 0; n < 254; n++) leak_cycle();
        check_all("sat255", 1'b1, 1'b1, 2'd0, 2'd0, 8'hFF, 8'hFF);
        ev_hits = 0;
        leak_cycle();
        chk("sat.pulses", 32'(ev_hits), 32'd1);
        check_all("sat_hold", 1'b1, 1'b1, 2'd0, 2'd0, 8'hFF, 8'hFF);

        // Reset mid-debounce discards history; re-debounce from zero
        do_reset();
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge iClk);
        repeat (10) tick();
        chk("rst.pend", 32'(bus.oDBG_Large_FSM), 32'd1);
        iRst = 1'b1;
        @(negedge iClk);
        chk("rst.clear", 32'(bus.oDBG_Large_FSM), 32'd0);
        iRst = 1'b0;
        repeat (4) @(negedge iClk);
        repeat (19) tick();
        chk("rst.det19", 32'(bus.oLarge_Leak_Detect_N), 32'd1);
        chk("rst.fsm19", 32'(bus.oDBG_Large_FSM), 32'd1);
        tick();
        chk("rst.det20", 32'(bus.oLarge_Leak_Detect_N), 32'd0);
        chk("rst.cnt", 32'(bus.oLarge_Evt_Cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
